// File: rtl/camera_main_fsm.sv
// Main sequencer for the 2x2 pixel-array camera: IDLE -> EXPOSURE -> READOUT.
// Every strobe is registered and decoded from the next state so all outputs move together.
module camera_main_fsm #(
  parameter int PHASE_CYCLES = 1,
  parameter int CNT_W        = 5
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Init,
  input  logic [CNT_W-1:0] i_count_time,
  output logic [1:0]       o_Main_FSM,
  output logic             o_Erase,
  output logic             o_Expose,
  output logic             o_NRE_1,
  output logic             o_NRE_2,
  output logic             o_ADC,
  output logic             o_Busy,
  output logic             o_Frame_done
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    EXPOSURE = 2'b01,
    READOUT  = 2'b10
  } state_e;

  localparam logic [3:0] SUB_LAST = 4'(PHASE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [3:0] sub_q, sub_d;
  logic       preInit_q;
  logic       startReq;

  logic erase_q, erase_d;
  logic expose_q, expose_d;
  logic nre1_q, nre1_d;
  logic nre2_q, nre2_d;
  logic adc_q, adc_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  assign startReq = i_Init & ~preInit_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    sub_d   = sub_q;
    case (state_q)
      IDLE: begin
        phase_d = 3'd0;
        sub_d   = 4'd0;
        if (startReq) state_d = EXPOSURE;
      end
      EXPOSURE: begin
        if (i_count_time == '0) begin
          state_d = READOUT;
          phase_d = 3'd0;
          sub_d   = 4'd0;
        end
      end
      READOUT: begin
        if (sub_q == SUB_LAST) begin
          sub_d = 4'd0;
          if (phase_q == 3'd7) begin
            state_d = IDLE;
            phase_d = 3'd0;
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end else begin
          sub_d = sub_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = 3'd0;
        sub_d   = 4'd0;
      end
    endcase
  end

  // Row 1 occupies phases 0-2 and row 2 phases 4-6, so the two enables can never overlap.
  always_comb begin
    erase_d  = (state_d == IDLE);
    expose_d = (state_d == EXPOSURE);
    busy_d   = (state_d != IDLE);
    done_d   = (state_q == READOUT) && (state_d == IDLE);
    nre1_d   = 1'b1;
    nre2_d   = 1'b1;
    adc_d    = 1'b0;
    if (state_d == READOUT) begin
      case (phase_d)
        3'd0, 3'd2: nre1_d = 1'b0;
        3'd1: begin
          nre1_d = 1'b0;
          adc_d  = 1'b1;
        end
        3'd4, 3'd6: nre2_d = 1'b0;
        3'd5: begin
          nre2_d = 1'b0;
          adc_d  = 1'b1;
        end
        default: begin
          nre1_d = 1'b1;
          nre2_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q   <= IDLE;
      phase_q   <= 3'd0;
      sub_q     <= 4'd0;
      preInit_q <= 1'b0;
      erase_q   <= 1'b1;
      expose_q  <= 1'b0;
      nre1_q    <= 1'b1;
      nre2_q    <= 1'b1;
      adc_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      sub_q     <= sub_d;
      preInit_q <= i_Init;
      erase_q   <= erase_d;
      expose_q  <= expose_d;
      nre1_q    <= nre1_d;
      nre2_q    <= nre2_d;
      adc_q     <= adc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_Main_FSM   = state_q;
  assign o_Erase      = erase_q;
  assign o_Expose     = expose_q;
  assign o_NRE_1      = nre1_q;
  assign o_NRE_2      = nre2_q;
  assign o_ADC        = adc_q;
  assign o_Busy       = busy_q;
  assign o_Frame_done = done_q;

endmodule

// File: tb/tb_camera_main_fsm.sv
// Scoreboard bench for camera_main_fsm: two instances (1 and 3 cycles per readout phase)
// share Init/reset; a timeline model predicts every cycle's outputs from the start edge.
module tb_camera_main_fsm;

  localparam int CNT_W = 5;
  localparam int PA    = 1;
  localparam int PB    = 3;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             init = 1'b0;
  logic [CNT_W-1:0] countA = '0;
  logic [CNT_W-1:0] countB = '0;

  logic [1:0] fsmA, fsmB;
  logic eraseA, exposeA, nre1A, nre2A, adcA, busyA, doneA;
  logic eraseB, exposeB, nre1B, nre2B, adcB, busyB, doneB;
  logic [8:0] actA, actB;

  assign actA = {fsmA, eraseA, exposeA, nre1A, nre2A, adcA, busyA, doneA};
  assign actB = {fsmB, eraseB, exposeB, nre1B, nre2B, adcB, busyB, doneB};

  always #5 clk = ~clk;

  camera_main_fsm #(.PHASE_CYCLES(PA), .CNT_W(CNT_W)) dutA (
    .i_Clock(clk), .i_Reset(rstN), .i_Init(init), .i_count_time(countA),
    .o_Main_FSM(fsmA), .o_Erase(eraseA), .o_Expose(exposeA), .o_NRE_1(nre1A),
    .o_NRE_2(nre2A), .o_ADC(adcA), .o_Busy(busyA), .o_Frame_done(doneA)
  );

  camera_main_fsm #(.PHASE_CYCLES(PB), .CNT_W(CNT_W)) dutB (
    .i_Clock(clk), .i_Reset(rstN), .i_Init(init), .i_count_time(countB),
    .o_Main_FSM(fsmB), .o_Erase(eraseB), .o_Expose(exposeB), .o_NRE_1(nre1B),
    .o_NRE_2(nre2B), .o_ADC(adcB), .o_Busy(busyB), .o_Frame_done(doneB)
  );

  int vecCount = 0;
  int missCount = 0;
  int edgeNum = 0;
  int forceN = -1;
  bit prevInit = 1'b0;
  bit active [2];
  int startEdge [2];
  int nExp [2];
  logic [8:0] expQA [$];
  logic [8:0] expQB [$];

  function automatic int phaseCycles(int i);
    return (i == 0) ? PA : PB;
  endfunction

  // Vector layout: {state[1:0], erase, expose, nre1, nre2, adc, busy, frame_done}
  function automatic logic [8:0] idleVec(logic done);
    return {2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, done};
  endfunction

  // u = edges since the accepted start edge: exposure for u in 0..n, then 8*p readout cycles.
  function automatic logic [8:0] expectedAfter(int u, int n, int p);
    int r, ph;
    logic nre1, nre2, adc;
    if (u <= n) return {2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    r = u - (n + 1);
    if (r < 8 * p) begin
      ph   = r / p;
      nre1 = !(ph <= 2);
      nre2 = !(ph >= 4 && ph <= 6);
      adc  = (ph == 1) || (ph == 5);
      return {2'b10, 1'b0, 1'b0, nre1, nre2, adc, 1'b1, 1'b0};
    end
    return idleVec(1'b1);
  endfunction

  function automatic logic [8:0] stepModel(int i, logic initNow);
    int u;
    logic [8:0] ev;
    if (active[i]) begin
      u  = edgeNum - startEdge[i];
      ev = expectedAfter(u, nExp[i], phaseCycles(i));
      if (u >= nExp[i] + 1 + 8 * phaseCycles(i)) active[i] = 1'b0;
    end else if (initNow && !prevInit) begin
      active[i]    = 1'b1;
      startEdge[i] = edgeNum;
      nExp[i]      = (forceN >= 0) ? forceN : int'($urandom_range(0, 31));
      ev = expectedAfter(0, nExp[i], phaseCycles(i));
    end else begin
      ev = idleVec(1'b0);
    end
    return ev;
  endfunction

  // Emulates the exposure-time controller; outside exposure the count is junk the DUT must ignore.
  function automatic logic [CNT_W-1:0] countFor(int i);
    int u;
    if (active[i]) begin
      u = edgeNum + 1 - startEdge[i];
      if (u - 1 >= 0 && u - 1 <= nExp[i]) return CNT_W'(nExp[i] - (u - 1));
    end
    return CNT_W'($urandom_range(0, 31));
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s edge %0d: got {fsm,erase,expose,nre1,nre2,adc,busy,done}=%b expected %b",
               name, edgeNum, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic initVal);
    @(negedge clk);
    init   = initVal;
    countA = countFor(0);
    countB = countFor(1);
    @(posedge clk);
    edgeNum++;
    expQA.push_back(stepModel(0, initVal));
    expQB.push_back(stepModel(1, initVal));
    prevInit = initVal;
  endtask

  always @(posedge clk) begin
    logic [8:0] e;
    #1;
    if (expQA.size() > 0) begin
      e = expQA.pop_front();
      checkOutput("instA", actA, e);
    end
    if (expQB.size() > 0) begin
      e = expQB.pop_front();
      checkOutput("instB", actB, e);
    end
  end

  task automatic resetMidReadout();
    bit found = 1'b0;
    forceN = 2;
    applyStimulus(1'b1);
    for (int k = 0; k < 40 && !found; k++) begin
      applyStimulus(1'b0);
      if (active[0] && (edgeNum - startEdge[0] == nExp[0] + 1 + PA)) found = 1'b1;
    end
    if (!found) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL reset_setup: readout phase 1 not reached, got edge %0d required within 40", edgeNum);
    end
    #2;
    rstN = 1'b0;
    init = 1'b0;
    #1;
    checkOutput("async_reset_A", actA, idleVec(1'b0));
    checkOutput("async_reset_B", actB, idleVec(1'b0));
    active[0] = 1'b0;
    active[1] = 1'b0;
    prevInit  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("in_reset_A", actA, idleVec(1'b0));
    checkOutput("in_reset_B", actB, idleVec(1'b0));
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    active[0] = 1'b0;
    active[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_A", actA, idleVec(1'b0));
    checkOutput("reset_B", actB, idleVec(1'b0));
    @(negedge clk);
    rstN = 1'b1;

    forceN = 2;
    repeat (4) applyStimulus(1'b0);
    applyStimulus(1'b1);
    repeat (40) applyStimulus(1'b0);

    forceN = 30;
    applyStimulus(1'b1);
    repeat (70) applyStimulus(1'b0);

    forceN = 5;
    repeat (60) applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    repeat (45) applyStimulus(1'b0);

    forceN = 2;
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    repeat (4) begin
      applyStimulus(1'b1);
      applyStimulus(1'b0);
    end
    repeat (40) applyStimulus(1'b0);

    forceN = -1;
    repeat (1500) applyStimulus($urandom_range(0, 7) == 0);
    repeat (60) applyStimulus(1'b0);

    resetMidReadout();
    repeat (5) applyStimulus(1'b0);

    forceN = 0;
    applyStimulus(1'b1);
    repeat (35) applyStimulus(1'b0);

    repeat (2) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/camera_main_fsm.md
Name: camera_main_fsm

Overview:
Top-level sequencer for the 2x2 pixel-array camera. It owns the IDLE/EXPOSURE/READOUT state and publishes it on o_Main_FSM, which the exposure-time controller uses to adjust or count down its value. It drives the pixel-array control strobes: Erase, Expose, NRE_1, NRE_2 and ADC. It ends exposure when the exposure-time counter reaches 0, then runs a fixed two-row readout sequence.

Parameters:
PHASE_CYCLES, 1, clock cycles spent in each readout phase (range 1..15)
CNT_W, 5, width of the exposure-time input

Ports:
i_Clock  input  1  system clock; all flops use the rising edge
i_Reset  input  1  reset, asynchronous, active-low (0 = reset)
i_Init  input  1  start request from the pushbutton; sampled level, acted on at its rising edge
i_count_time  input  CNT_W  current exposure count from the exposure-time controller
o_Main_FSM  output  2  state code: 00 IDLE, 01 EXPOSURE, 10 READOUT (11 never driven)
o_Erase  output  1  pixel erase, high only in IDLE
o_Expose  output  1  pixel expose, high only in EXPOSURE
o_NRE_1  output  1  row-1 readout enable, active-low
o_NRE_2  output  1  row-2 readout enable, active-low
o_ADC  output  1  ADC sample strobe
o_Busy  output  1  high whenever state is not IDLE
o_Frame_done  output  1  one-cycle pulse on the READOUT-to-IDLE transition

Behaviour:
- Reset (i_Reset=0, async):
  - state=IDLE, phase counter=0, init-edge register=0.
  - Outputs: o_Erase=1, o_Expose=0, o_NRE_1=1, o_NRE_2=1, o_ADC=0, o_Busy=0, o_Frame_done=0, o_Main_FSM=00.
  - Reset asserted mid-exposure or mid-readout aborts immediately. No o_Frame_done pulse is produced.
- All outputs are registered. They are decoded from the next state and phase so that they change on the same edge as o_Main_FSM.
- Init edge detection:
  - pre_init <= i_Init every cycle, in every state.
  - A start fires when i_Init=1 and pre_init=0, and only while in IDLE.
  - Edges during EXPOSURE or READOUT are discarded, not queued.
  - If Init is held high through a frame, the return to IDLE does not retrigger.
- IDLE:
  - Outputs at their reset values.
  - On a start at edge k: state=EXPOSURE, o_Expose=1, o_Erase=0 from edge k+1.
- EXPOSURE:
  - The state is left on the first edge at which i_count_time==0 is sampled. The next state is READOUT with phase=0.
  - With count N loaded on entry, EXPOSURE lasts N+1 cycles, because the external counter decrements once per EXPOSURE cycle.
  - If N=0 on entry, EXPOSURE lasts exactly 1 cycle.
- READOUT: 8 phases, each PHASE_CYCLES long. The phase counter advances when its sub-counter hits PHASE_CYCLES-1.
  - P0: NRE_1=0
  - P1: NRE_1=0, ADC=1
  - P2: NRE_1=0
  - P3: all high/idle (row gap)
  - P4: NRE_2=0
  - P5: NRE_2=0, ADC=1
  - P6: NRE_2=0
  - P7: all idle
  - At the end of P7: state=IDLE, o_Frame_done=1 for exactly 1 cycle, o_Erase=1.
  - Erase and Expose are 0 throughout READOUT. NRE_1 and NRE_2 are never low simultaneously.
  - Total READOUT length = 8*PHASE_CYCLES cycles.
- i_count_time is ignored outside EXPOSURE.
- Illegal state 11, if ever reached, returns to IDLE on the next edge.

Test Plan:
- Reset check: assert i_Reset=0 mid-READOUT P1 → asynchronously o_Main_FSM=00, o_Erase=1, o_NRE_1=1, o_ADC=0, and no o_Frame_done.
- Nominal frame: count model starts at 2, PHASE_CYCLES=1, i_Init rises at cycle 5 →
  - o_Main_FSM=01 at cycle 6 for 3 cycles (2,1,0);
  - READOUT for 8 cycles;
  - o_ADC high exactly twice, once with NRE_1=0 and once with NRE_2=0;
  - o_Frame_done single pulse; o_Erase=1 afterwards.
- Maximum exposure: count=30 → EXPOSURE lasts 31 cycles, o_Expose=1 throughout, o_Busy=1 for 31+8 cycles.
- Init held high through a whole frame → exactly one frame, no restart after return to IDLE. Release then re-press → second frame starts 1 cycle after the edge.
- Init pulses during EXPOSURE and READOUT → ignored; frame timing is identical to the nominal case.
- PHASE_CYCLES=3 → READOUT lasts 24 cycles, each ADC pulse is 3 cycles wide, and the NRE_1/NRE_2 low windows are 9 cycles each and non-overlapping.
